// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory.
// Each accepted access is bounds/alignment checked, then either issued for ACCESS_CYCLES or rejected.
module data_mem_arbiter #(
    parameter int MEM_BYTES     = 720,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [1:0]   req_we,
    input  logic [3:0]   req_size,
    input  logic [127:0] req_addr,
    input  logic [127:0] req_wdata,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic         err,
    output logic [63:0]  rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [1:0]   mem_size,
    output logic [63:0]  mem_addr,
    output logic [63:0]  mem_wdata,
    input  logic [63:0]  mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic        rr_ptr;
    logic        owner;
    logic        we_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [3:0]  cnt;

    logic        win;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic [3:0]  acc_bytes;
    logic        aligned;
    logic [64:0] addr_end;
    logic        valid;
    logic        last_issue;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   size_bytes = 4'd4;
            2'b01:   size_bytes = 4'd2;
            2'b10:   size_bytes = 4'd1;
            default: size_bytes = 4'd8;
        endcase
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 64'h0000_0000_FFFF_FFFF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_0000_00FF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Winner selection and acceptance-time validity check
    always_comb begin
        win       = (req == 2'b11) ? rr_ptr : req[1];
        sel_we    = win ? req_we[1] : req_we[0];
        sel_size  = win ? req_size[3:2] : req_size[1:0];
        sel_addr  = win ? req_addr[127:64] : req_addr[63:0];
        sel_wdata = win ? req_wdata[127:64] : req_wdata[63:0];
        acc_bytes = size_bytes(sel_size);
        // Low 3 bits of (bytes - 1) give the alignment mask; 8 wraps to 7 in 3 bits
        aligned   = (sel_addr[2:0] & (acc_bytes[2:0] - 3'd1)) == 3'd0;
        addr_end  = {1'b0, sel_addr} + {61'd0, acc_bytes};
        valid     = aligned && (addr_end <= 65'(MEM_BYTES));
    end

    assign last_issue = (cnt == 4'(ACCESS_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = valid ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        done      = 2'b00;
        case (state)
            ISSUE: begin
                mem_read  = !we_q;
                mem_write = we_q;
            end
            RESP:    done = owner ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    assign mem_size  = size_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= 1'b0;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            cnt     <= 4'd0;
            gnt     <= 2'b00;
            err     <= 1'b0;
            rdata   <= 64'd0;
        end else begin
            gnt <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner   <= win;
                        we_q    <= sel_we;
                        size_q  <= sel_size;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        cnt     <= 4'd0;
                        gnt     <= win ? 2'b10 : 2'b01;
                        if (!valid) begin
                            err   <= 1'b1;
                            rdata <= 64'd0;
                        end
                    end
                end
                ISSUE: begin
                    if (last_issue) begin
                        cnt   <= 4'd0;
                        err   <= 1'b0;
                        rdata <= we_q ? 64'd0 : (mem_rdata & size_mask(size_q));
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP:    rr_ptr <= ~owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised bench for data_mem_arbiter with a byte-array memory and a transaction-level reference model.
module tb_data_mem_arbiter;

    localparam int MEM = 720;
    localparam int AC  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req;
    logic [1:0]   req_we;
    logic [3:0]   req_size;
    logic [127:0] req_addr;
    logic [127:0] req_wdata;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         err;
    logic [63:0]  rdata;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_size;
    logic [63:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata;

    logic [7:0]   mem     [0:MEM-1];
    logic [7:0]   seed    [0:MEM-1];
    logic [7:0]   ref_mem [0:MEM-1];
    logic         preload;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_arbiter #(.MEM_BYTES(MEM), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err),
        .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] size);
        case (size)
            2'b00:   return 4;
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 8;
        endcase
    endfunction

    // Memory returns all 8 bytes regardless of size so the DUT must zero-extend itself
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM; i++) mem[i] <= seed[i];
        end else if (mem_write) begin
            for (int i = 0; i < 8; i++)
                if (i < nbytes(mem_size) && mem_addr < 64'(MEM - i))
                    mem[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 8; i++)
            mem_rdata[8*i +: 8] = (mem_addr < 64'(MEM - i)) ? mem[int'(mem_addr) + i] : 8'hA5;
    end

    function automatic logic [63:0] model_read(input longint unsigned a, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
        return v;
    endfunction

    task automatic model_write(input longint unsigned a, input int n, input logic [63:0] d);
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
    endtask

    function automatic logic model_valid(input longint unsigned a, input int n);
        return (a % longint'(n) == 0) && (a <= longint'(MEM - n));
    endfunction

    task automatic set_port(input int p, input logic we, input logic [1:0] sz,
                            input logic [63:0] a, input logic [63:0] d);
        req[p]              = 1'b1;
        req_we[p]           = we;
        req_size[2*p +: 2]  = sz;
        req_addr[64*p +: 64]  = a;
        req_wdata[64*p +: 64] = d;
    endtask

    // Drives one access from an idle negedge; returns observations, ends at an idle negedge
    task automatic run_access(input int p, input logic we, input logic [1:0] sz,
                              input logic [63:0] a, input logic [63:0] d,
                              output int gnt_cyc, output int done_cyc,
                              output int rd_cyc, output int wr_cyc, output logic both,
                              output logic [63:0] rd, output logic e, output logic pulse_ok);
        gnt_cyc = -1; done_cyc = -1; rd_cyc = 0; wr_cyc = 0; both = 0; rd = '0; e = 0;
        set_port(p, we, sz, a, d);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_read)  rd_cyc++;
            if (mem_write) wr_cyc++;
            if (mem_read && mem_write) both = 1;
            if (gnt[p] && gnt_cyc < 0) begin
                gnt_cyc = c;
                req[p] = 1'b0;
                req_addr[64*p +: 64]  = {$urandom, $urandom};
                req_wdata[64*p +: 64] = {$urandom, $urandom};
            end
            if (done[p]) begin
                done_cyc = c;
                rd = rdata;
                e  = err;
                break;
            end
        end
        req[p] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        pulse_ok = (done == 2'b00) && (gnt == 2'b00);
    endtask

    task automatic test_reset();
        logic [200:0] outs;
        req = '0; req_we = '0; req_size = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < MEM; i++) begin
            seed[i]    = 8'($urandom);
            ref_mem[i] = seed[i];
        end
        preload = 1'b1;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs = {gnt, done, err, rdata, mem_read, mem_write, mem_size, mem_addr, mem_wdata};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
        end
        preload = 1'b0;
        reset   = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int g, dn, rc, wc; logic both, e, pok; logic [63:0] rd;
        run_access(0, 1'b1, 2'b11, 64'h10, 64'h1122334455667788, g, dn, rc, wc, both, rd, e, pok);
        model_write(64'h10, 8, 64'h1122334455667788);
        n_checks++;
        if (g !== 1 || dn !== AC + 1 || e !== 1'b0 || wc !== AC || rc !== 0 || !pok) begin
            n_fail++;
            $display("[TB] FAIL write_double: got gnt@%0d done@%0d err=%b wr=%0d rd=%0d pulse=%b expected gnt@1 done@%0d err=0 wr=%0d rd=0 pulse=1",
                     g, dn, e, wc, rc, pok, AC + 1, AC);
        end
        run_access(1, 1'b0, 2'b11, 64'h10, 64'h0, g, dn, rc, wc, both, rd, e, pok);
        n_checks++;
        if (rd !== 64'h1122334455667788 || e !== 1'b0 || dn !== AC + 1 || rc !== AC) begin
            n_fail++;
            $display("[TB] FAIL read_double: got rdata=%h err=%b done@%0d rd=%0d expected 1122334455667788 0 %0d %0d",
                     rd, e, dn, rc, AC + 1, AC);
        end
        run_access(1, 1'b0, 2'b10, 64'h10, 64'h0, g, dn, rc, wc, both, rd, e, pok);
        n_checks++;
        if (rd !== 64'h88 || e !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL read_byte: got rdata=%h err=%b expected 88 0", rd, e);
        end
    endtask

    task automatic test_round_robin();
        int gq[$]; int run, max_run, dones; logic overlap;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_port(0, 1'b0, 2'b11, 64'h10, 64'h0);
        set_port(1, 1'b0, 2'b11, 64'h18, 64'h0);
        run = 0; max_run = 0; dones = 0; overlap = 0;
        for (int c = 1; c <= 4 * (AC + 2); c++) begin
            @(posedge clk);
            @(negedge clk);
            if (gnt == 2'b11) overlap = 1;
            if (gnt[0]) gq.push_back(0);
            if (gnt[1]) gq.push_back(1);
            if (done != 2'b00) dones++;
            if (mem_read || mem_write) run++; else run = 0;
            if (run > max_run) max_run = run;
        end
        req = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (gq.size() != 4 || overlap || dones != 4) begin
            n_fail++;
            $display("[TB] FAIL rr_count: got grants=%0d dones=%0d overlap=%b expected 4 4 0", gq.size(), dones, overlap);
        end
        for (int k = 0; k < gq.size() && k < 4; k++) begin
            n_checks++;
            if (gq[k] != k % 2) begin
                n_fail++;
                $display("[TB] FAIL rr_order[%0d]: got port %0d expected port %0d", k, gq[k], k % 2);
            end
        end
        n_checks++;
        if (max_run != AC) begin
            n_fail++;
            $display("[TB] FAIL rr_strobe_gap: got longest strobe run %0d expected %0d", max_run, AC);
        end
    endtask

    task automatic test_invalid();
        int g, dn, rc, wc, n; logic both, e, pok, exp_ok; logic [63:0] rd;
        int          tp [5] = '{0, 1, 0, 1, 0};
        logic [1:0]  ts [5] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b01};
        logic [63:0] ta [5] = '{64'h2, 64'h2D0, 64'h2C8, 64'hFFFF_FFFF_FFFF_FFF8, 64'h2CF};
        for (int k = 0; k < 5; k++) begin
            n = nbytes(ts[k]);
            exp_ok = model_valid(ta[k], n);
            run_access(tp[k], 1'b0, ts[k], ta[k], 64'h0, g, dn, rc, wc, both, rd, e, pok);
            n_checks++;
            if (exp_ok) begin
                if (e !== 1'b0 || dn !== AC + 1 || rd !== model_read(ta[k], n)) begin
                    n_fail++;
                    $display("[TB] FAIL edge_valid[%0d]: got err=%b done@%0d rdata=%h expected 0 %0d %h",
                             k, e, dn, rd, AC + 1, model_read(ta[k], n));
                end
            end else if (e !== 1'b1 || g !== 1 || dn !== 1 || rc !== 0 || wc !== 0) begin
                n_fail++;
                $display("[TB] FAIL reject[%0d]: got err=%b gnt@%0d done@%0d rd=%0d wr=%0d expected 1 1 1 0 0",
                         k, e, g, dn, rc, wc);
            end
        end
    endtask

    task automatic test_reset_mid_issue();
        logic [200:0] outs; logic saw_done, wr_before, both, e, pok; logic [63:0] d, rd;
        int g, dn, rc, wc;
        d = {$urandom, $urandom};
        set_port(0, 1'b1, 2'b11, 64'h40, d);
        @(posedge clk);
        @(negedge clk);
        req = '0;
        @(posedge clk);
        #1;
        wr_before = mem_write;
        #1;
        reset = 1'b1;
        #1;
        outs = {gnt, done, err, rdata, mem_read, mem_write, mem_size, mem_addr, mem_wdata};
        model_write(64'h40, 8, d);
        n_checks++;
        if (wr_before !== 1'b1 || outs !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_issue: got strobe_before=%b outs=%h expected 1 and 0", wr_before, outs);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (done != 2'b00) saw_done = 1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("[TB] FAIL reset_no_done: got done pulse after abort expected none");
        end
        run_access(1, 1'b0, 2'b11, 64'h80, 64'h0, g, dn, rc, wc, both, rd, e, pok);
        n_checks++;
        if (g !== 1 || dn !== AC + 1 || e !== 1'b0 || rd !== model_read(64'h80, 8)) begin
            n_fail++;
            $display("[TB] FAIL after_reset_access: got gnt@%0d done@%0d err=%b rdata=%h expected 1 %0d 0 %h",
                     g, dn, e, rd, AC + 1, model_read(64'h80, 8));
        end
    endtask

    task automatic test_random();
        int g, dn, rc, wc, n, p, r; logic both, e, pok, we, ok; logic [1:0] sz;
        logic [63:0] a, d, rd, exp_rd;
        for (int k = 0; k < 40; k++) begin
            p  = int'($urandom % 2);
            we = 1'($urandom);
            sz = 2'($urandom);
            n  = nbytes(sz);
            r  = int'($urandom % 8);
            d  = {$urandom, $urandom};
            a  = (r == 0) ? {$urandom, $urandom} : 64'($urandom % (MEM + 16));
            if (r > 0 && r < 6) a = a & ~64'(n - 1);
            ok = model_valid(a, n);
            exp_rd = (ok && !we) ? model_read(a, n) : 64'h0;
            run_access(p, we, sz, a, d, g, dn, rc, wc, both, rd, e, pok);
            if (ok && we) model_write(a, n, d);
            n_checks++;
            if (g !== 1 || dn !== (ok ? AC + 1 : 1) || e !== !ok || both || !pok
                || rc !== ((ok && !we) ? AC : 0) || wc !== ((ok && we) ? AC : 0)
                || (ok && rd !== exp_rd)) begin
                n_fail++;
                $display("[TB] FAIL random[%0d] p%0d we=%b sz=%0d a=%h: got gnt@%0d done@%0d err=%b rd=%0d wr=%0d rdata=%h expected gnt@1 done@%0d err=%b rdata=%h",
                         k, p, we, sz, a, g, dn, e, rc, wc, rd, ok ? AC + 1 : 1, !ok, exp_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_invalid();
        test_reset_mid_issue();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
